mem_stage_ls: RTL and testbench

//  Parametrised MEM pipeline stage for variable-latency data SRAM. Sits between EX and WB;

---
 rtl/mem_stage_ls.sv | 82 ++++++++
 tb/tb_mem_stage_ls.sv | 160 ++++++++++++++++
 2 files changed

// File: rtl/mem_stage_ls.sv
// mem_stage_ls: MEM pipeline stage for a variable-latency data SRAM.
// Holds one instruction, waits for its data_ok, extends load data and buffers it while WB stalls.
module mem_stage_ls #(
    parameter int DATA_W = 32,
    parameter int PC_W   = 32,
    parameter int RA_W   = 5
) (
    input  logic                         clk_i,
    input  logic                         resetn_i,
    input  logic                         flush_i,
    input  logic                         ex_to_mem_valid_i,
    input  logic [PC_W+6+RA_W+DATA_W-1:0] ex_to_mem_bus_i,
    output logic                         mem_allowin_o,
    input  logic                         wb_allowin_i,
    output logic                         mem_to_wb_valid_o,
    output logic [1+RA_W+DATA_W+PC_W-1:0] mem_to_wb_bus_o,
    output logic [2+RA_W+DATA_W-1:0]     mem_to_id_bus_o,
    input  logic                         data_sram_data_ok_i,
    input  logic [DATA_W-1:0]            data_sram_rdata_i
);
    localparam int EXW = PC_W + 6 + RA_W + DATA_W;

    logic           mem_valid_q, mem_valid_d;
    logic           buf_valid_q, buf_valid_d;
    logic           drop_q, drop_d;
    logic [EXW-1:0] ex_q, ex_d;
    logic [DATA_W-1:0] buf_q, buf_d;

    logic [PC_W-1:0]   pc;
    logic [2:0]        lt;
    logic              rm, mw, we;
    logic [RA_W-1:0]   wa;
    logic [DATA_W-1:0] alu, raw, ld_data, wdata;
    logic [7:0]        b;
    logic [15:0]       h;
    logic              in_wait, ready_go, load, sgn, load_pending;

    assign {pc, lt, rm, mw, we, wa, alu} = ex_q;

    assign in_wait       = mem_valid_q & mw & ~buf_valid_q;
    // A response arriving while a drop is owed belongs to the flushed request.
    assign ready_go      = ~mw | buf_valid_q | (data_sram_data_ok_i & ~drop_q);
    assign mem_allowin_o = ~drop_q & (~mem_valid_q | (ready_go & wb_allowin_i));
    assign mem_to_wb_valid_o = mem_valid_q & ready_go & ~flush_i;
    assign load          = ex_to_mem_valid_i & mem_allowin_o & ~flush_i;
    assign load_pending  = mem_valid_q & rm & ~ready_go;

    assign raw     = buf_valid_q ? buf_q : data_sram_rdata_i;
    assign b       = 8'(raw >> {alu[1:0], 3'b000});
    assign h       = 16'(raw >> {alu[1], 4'b0000});
    assign sgn     = ~lt[2];
    assign ld_data = (lt[1:0] == 2'b01) ? {{(DATA_W-8){sgn & b[7]}}, b} :
                     (lt[1:0] == 2'b10) ? {{(DATA_W-16){sgn & h[15]}}, h} : raw;
    assign wdata   = rm ? ld_data : alu;

    assign mem_to_wb_bus_o = {we & mem_to_wb_valid_o, wa, wdata, pc};
    assign mem_to_id_bus_o = {we & mem_valid_q & ~flush_i, wa, wdata, load_pending};

    always_comb begin
        mem_valid_d = flush_i ? 1'b0 : mem_allowin_o ? load : mem_valid_q;
        ex_d        = load ? ex_to_mem_bus_i : ex_q;
        buf_valid_d = (flush_i | mem_allowin_o) ? 1'b0 : (in_wait & data_sram_data_ok_i) ? 1'b1 : buf_valid_q;
        buf_d       = (in_wait & data_sram_data_ok_i) ? data_sram_rdata_i : buf_q;
        drop_d      = drop_q ? ~data_sram_data_ok_i : (flush_i & in_wait & ~data_sram_data_ok_i);
    end

    always_ff @(posedge clk_i or negedge resetn_i) begin
        if (!resetn_i) begin
            mem_valid_q <= 1'b0;
            buf_valid_q <= 1'b0;
            drop_q      <= 1'b0;
            ex_q        <= '0;
            buf_q       <= '0;
        end else begin
            mem_valid_q <= mem_valid_d;
            buf_valid_q <= buf_valid_d;
            drop_q      <= drop_d;
            ex_q        <= ex_d;
            buf_q       <= buf_d;
        end
    end
endmodule

// File: tb/tb_mem_stage_ls.sv
// tb_mem_stage_ls: cycle table with a scoreboard of expected WB writes, plus an async-reset sequence.
module tb_mem_stage_ls;
    logic        clk = 1'b0, resetn = 1'b0, flush = 1'b0, exv = 1'b0, wba = 1'b1, ok = 1'b0;
    logic [74:0] ex_bus = '0;
    logic [31:0] rdata = '0;
    logic        allowin, wbv;
    logic [69:0] wb_bus;
    logic [38:0] id_bus;

    mem_stage_ls dut (
        .clk_i(clk), .resetn_i(resetn), .flush_i(flush),
        .ex_to_mem_valid_i(exv), .ex_to_mem_bus_i(ex_bus),
        .mem_allowin_o(allowin), .wb_allowin_i(wba),
        .mem_to_wb_valid_o(wbv), .mem_to_wb_bus_o(wb_bus), .mem_to_id_bus_o(id_bus),
        .data_sram_data_ok_i(ok), .data_sram_rdata_i(rdata)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic fl, ev; logic [2:0] lt; logic rm, mw, we; logic [4:0] wa; logic [31:0] alu;
        logic wba, ok; logic [31:0] rd, ewd; logic ea, ewv, elp;
    } vec_t;
    typedef struct { logic [31:0] wd; logic [4:0] wa; logic we; logic [31:0] pc; } sb_t;

    vec_t tv[33];
    sb_t  q[$];
    sb_t  e;
    int   tests = 0, fails = 0;

    function automatic vec_t r(input logic fl, ev, input logic [2:0] lt, input logic rm, mw, we,
                               input logic [4:0] wa, input logic [31:0] alu, input logic wb, k,
                               input logic [31:0] rd, ewd, input logic ea, ewv, elp);
        vec_t v;
        v.fl = fl; v.ev = ev; v.lt = lt; v.rm = rm; v.mw = mw; v.we = we; v.wa = wa; v.alu = alu;
        v.wba = wb; v.ok = k; v.rd = rd; v.ewd = ewd; v.ea = ea; v.ewv = ewv; v.elp = elp;
        return v;
    endfunction

    function automatic vec_t idle(input logic fl, wb, k, input logic [31:0] rd, input logic ea, ewv, elp);
        return r(fl, 1'b0, 3'b000, 1'b0, 1'b0, 1'b0, 5'd0, 32'd0, wb, k, rd, 32'd0, ea, ewv, elp);
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    initial begin
        tv[0]  = idle(0, 1, 0, 32'h0, 1, 0, 0);
        tv[1]  = r(0, 1, 3'b000, 0, 0, 1, 5, 32'h1234_5678, 1, 0, 32'h0, 32'h1234_5678, 1, 0, 0);
        tv[2]  = idle(0, 1, 0, 32'h0, 1, 1, 0);
        tv[3]  = r(0, 1, 3'b001, 1, 1, 1, 6, 32'h0000_0103, 1, 0, 32'h0, 32'hFFFF_FF80, 1, 0, 0);
        tv[4]  = idle(0, 1, 0, 32'h0, 0, 0, 1);
        tv[5]  = idle(0, 1, 0, 32'h0, 0, 0, 1);
        tv[6]  = r(0, 1, 3'b110, 1, 1, 1, 7, 32'h0000_0102, 1, 1, 32'h80FF_0000, 32'h0000_80FF, 1, 1, 0);
        tv[7]  = idle(0, 1, 1, 32'h80FF_0000, 1, 1, 0);
        tv[8]  = r(0, 1, 3'b000, 1, 1, 1, 8, 32'h0000_0200, 1, 0, 32'h0, 32'hDEAD_BEEF, 1, 0, 0);
        tv[9]  = idle(0, 0, 1, 32'hDEAD_BEEF, 0, 1, 0);
        tv[10] = idle(0, 0, 0, 32'h5555_5555, 0, 1, 0);
        tv[11] = idle(0, 0, 0, 32'hAAAA_AAAA, 0, 1, 0);
        tv[12] = idle(0, 0, 0, 32'h1212_1212, 0, 1, 0);
        tv[13] = idle(0, 1, 0, 32'h0BAD_F00D, 1, 1, 0);
        tv[14] = r(0, 1, 3'b000, 1, 1, 1, 9, 32'h0000_0300, 1, 0, 32'h0, 32'h0, 1, 0, 0);
        tv[15] = r(1, 1, 3'b000, 1, 1, 1, 10, 32'h0000_0304, 1, 0, 32'h0, 32'h0, 0, 0, 1);
        tv[16] = r(0, 1, 3'b000, 1, 1, 1, 10, 32'h0000_0304, 1, 0, 32'h0, 32'h2222_2222, 0, 0, 0);
        tv[17] = r(0, 1, 3'b000, 1, 1, 1, 10, 32'h0000_0304, 1, 0, 32'h0, 32'h2222_2222, 0, 0, 0);
        tv[18] = r(0, 1, 3'b000, 1, 1, 1, 10, 32'h0000_0304, 1, 1, 32'h1111_1111, 32'h2222_2222, 0, 0, 0);
        tv[19] = r(0, 1, 3'b000, 1, 1, 1, 10, 32'h0000_0304, 1, 0, 32'h0, 32'h2222_2222, 1, 0, 0);
        tv[20] = idle(0, 1, 1, 32'h2222_2222, 1, 1, 0);
        tv[21] = r(0, 1, 3'b000, 1, 1, 1, 11, 32'h0000_0400, 1, 0, 32'h0, 32'h0, 1, 0, 0);
        tv[22] = idle(1, 1, 1, 32'h3333_3333, 1, 0, 0);
        tv[23] = r(0, 1, 3'b000, 0, 0, 1, 12, 32'hA5A5_A5A5, 1, 0, 32'h0, 32'hA5A5_A5A5, 1, 0, 0);
        tv[24] = r(0, 1, 3'b000, 0, 1, 0, 13, 32'h0000_0500, 1, 0, 32'h0, 32'h0000_0500, 1, 1, 0);
        tv[25] = idle(0, 1, 0, 32'h0, 0, 0, 0);
        tv[26] = r(0, 1, 3'b010, 1, 1, 1, 14, 32'h0000_0600, 1, 1, 32'h0000_8001, 32'hFFFF_8001, 1, 1, 0);
        tv[27] = idle(0, 1, 0, 32'h0, 0, 0, 1);
        tv[28] = r(0, 1, 3'b101, 1, 1, 1, 15, 32'h0000_0701, 1, 1, 32'h0000_8001, 32'h0000_00AB, 1, 1, 0);
        tv[29] = idle(0, 1, 1, 32'h0000_AB00, 1, 1, 0);
        tv[30] = r(0, 1, 3'b011, 1, 1, 1, 16, 32'h0000_0803, 1, 0, 32'h0, 32'hCAFE_F00D, 1, 0, 0);
        tv[31] = idle(0, 1, 1, 32'hCAFE_F00D, 1, 1, 0);
        tv[32] = idle(0, 1, 1, 32'h7777_7777, 1, 0, 0);

        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_allowin", {31'd0, allowin}, 1);
        chk("rst_wb_valid", {31'd0, wbv}, 0);
        chk("rst_wb_we", {31'd0, wb_bus[69]}, 0);
        chk("rst_id_we", {31'd0, id_bus[38]}, 0);
        chk("rst_load_pending", {31'd0, id_bus[0]}, 0);
        resetn = 1'b1;

        for (int i = 0; i < 33; i++) begin
            logic [31:0] pc;
            @(posedge clk); #1;
            pc = 32'h1C00_0000 + 32'(i * 4);
            flush = tv[i].fl; exv = tv[i].ev; wba = tv[i].wba; ok = tv[i].ok; rdata = tv[i].rd;
            ex_bus = {pc, tv[i].lt, tv[i].rm, tv[i].mw, tv[i].we, tv[i].wa, tv[i].alu};
            @(negedge clk);
            chk($sformatf("row%0d_allowin", i), {31'd0, allowin}, {31'd0, tv[i].ea});
            chk($sformatf("row%0d_wb_valid", i), {31'd0, wbv}, {31'd0, tv[i].ewv});
            chk($sformatf("row%0d_load_pending", i), {31'd0, id_bus[0]}, {31'd0, tv[i].elp});
            if (wbv && wba) begin
                if (q.size() == 0) chk($sformatf("row%0d_unexpected_wb", i), 1, 0);
                else begin
                    e = q.pop_front();
                    chk($sformatf("row%0d_wdata", i), wb_bus[63:32], e.wd);
                    chk($sformatf("row%0d_waddr", i), {27'd0, wb_bus[68:64]}, {27'd0, e.wa});
                    chk($sformatf("row%0d_wb_we", i), {31'd0, wb_bus[69]}, {31'd0, e.we});
                    chk($sformatf("row%0d_pc", i), wb_bus[31:0], e.pc);
                    chk($sformatf("row%0d_id_wdata", i), id_bus[32:1], e.wd);
                    chk($sformatf("row%0d_id_we", i), {31'd0, id_bus[38]}, {31'd0, e.we});
                end
            end else if (flush && q.size() != 0) begin
                chk($sformatf("row%0d_flush_wb_we", i), {31'd0, wb_bus[69]}, 0);
                chk($sformatf("row%0d_flush_id_we", i), {31'd0, id_bus[38]}, 0);
                void'(q.pop_front());
            end
            if (tv[i].ev && allowin && !tv[i].fl)
                q.push_back('{wd: tv[i].ewd, wa: tv[i].wa, we: tv[i].we, pc: pc});
        end
        chk("scoreboard_drained", q.size(), 0);

        @(posedge clk); #1;
        flush = 0; ok = 0; wba = 1; exv = 1;
        ex_bus = {32'h1C00_1000, 3'b000, 1'b1, 1'b1, 1'b1, 5'd17, 32'h0000_0900};
        @(posedge clk); #1;
        exv = 0;
        chk("pre_reset_load_pending", {31'd0, id_bus[0]}, 1);
        #2 resetn = 1'b0;
        #1;
        chk("async_rst_allowin", {31'd0, allowin}, 1);
        chk("async_rst_load_pending", {31'd0, id_bus[0]}, 0);
        chk("async_rst_id_we", {31'd0, id_bus[38]}, 0);
        chk("async_rst_wb_valid", {31'd0, wbv}, 0);
        @(negedge clk) resetn = 1'b1;
        @(posedge clk); #1;
        ok = 1; rdata = 32'h9999_9999;
        @(negedge clk);
        chk("post_rst_stale_wb_valid", {31'd0, wbv}, 0);
        chk("post_rst_allowin", {31'd0, allowin}, 1);
        @(posedge clk); #1;
        ok = 0; exv = 1;
        ex_bus = {32'h1C00_2000, 3'b000, 1'b0, 1'b0, 1'b1, 5'd18, 32'h0F0F_0F0F};
        @(negedge clk);
        chk("post_rst_accept", {31'd0, allowin}, 1);
        @(posedge clk); #1;
        exv = 0;
        @(negedge clk);
        chk("post_rst_wb_valid", {31'd0, wbv}, 1);
        chk("post_rst_wdata", wb_bus[63:32], 32'h0F0F_0F0F);
        chk("post_rst_waddr", {27'd0, wb_bus[68:64]}, 18);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
